ball_controller: RTL and testbench

- Per-frame game-state controller for the Pong VGA path.
- Sequences ball motion: serve, play, miss; wall/paddle bounce; scoring.
- Fed by the sync generator's raster counters and display-area flag.
- Emits registered draw_ball/draw_paddle for the RGB mux. These are aligned with the one-cycle-registered colour outputs.
- Positions change only at the frame tick, so there is no tearing.

---
 rtl/pong_pkg.sv | 14 +
 rtl/ball_controller_axis_bounce.sv | 48 ++++
 rtl/ball_controller.sv | 193 +++++++++++++++++++
 tb/tb_ball_controller.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared Pong definitions: game-state encoding and default raster geometry.
// Used by the ball controller and the score/display blocks.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_MISS  = 2'd2
  } state_t;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

endpackage

// File: rtl/ball_controller_axis_bounce.sv
// Single-axis ball step: moves by STEP toward dir, clamping to the low/high
// limit and reversing direction when the next step would cross it.
module axis_bounce
  import pong_pkg::*;
#(
  parameter int W    = 10,
  parameter int STEP = 2
) (
  input  logic [W-1:0] pos,
  input  logic         dir,
  input  logic [W-1:0] lowLimit,
  input  logic [W-1:0] highLimit,
  output logic [W-1:0] nextPos,
  output logic         nextDir,
  output logic         hitHigh
);

  localparam logic [W:0] STEP_W = (W+1)'(STEP);

  logic [W:0] upSum_s;
  logic [W:0] lowSum_s;

  // One extra bit on the sums keeps the limit compares free of wrap-around.
  always_comb begin
    upSum_s  = {1'b0, pos} + STEP_W;
    lowSum_s = {1'b0, lowLimit} + STEP_W;
    nextPos  = pos;
    nextDir  = dir;
    hitHigh  = 1'b0;
    if (dir) begin
      if (upSum_s > {1'b0, highLimit}) begin
        nextPos = highLimit;
        nextDir = 1'b0;
        hitHigh = 1'b1;
      end else begin
        nextPos = upSum_s[W-1:0];
      end
    end else begin
      if ({1'b0, pos} < lowSum_s) begin
        nextPos = lowLimit;
        nextDir = 1'b1;
      end else begin
        nextPos = pos - STEP_W[W-1:0];
      end
    end
  end

endmodule

// File: rtl/ball_controller.sv
// Per-frame Pong ball/paddle controller: serve/play/miss sequencing, bounces,
// scoring, and registered draw flags aligned with the registered RGB path.
module ball_controller
  import pong_pkg::*;
#(
  parameter int H_ACTIVE    = pong_pkg::H_ACTIVE,
  parameter int V_ACTIVE    = pong_pkg::V_ACTIVE,
  parameter int BALL_SIZE   = 16,
  parameter int STEP        = 2,
  parameter int PADDLE_Y    = 464,
  parameter int PADDLE_W    = 64,
  parameter int MISS_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] counter_x,
  input  logic [8:0] counter_y,
  input  logic       in_display_area,
  input  logic [9:0] paddle_x,
  input  logic       serve,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic       draw_ball,
  output logic       draw_paddle,
  output logic [1:0] state,
  output logic [7:0] hit_count,
  output logic [3:0] miss_count
);

  localparam int          TW         = $clog2(MISS_FRAMES);
  localparam logic [9:0]  CENTRE_X   = 10'(H_ACTIVE/2 - BALL_SIZE/2);
  localparam logic [8:0]  CENTRE_Y   = 9'(V_ACTIVE/2 - BALL_SIZE/2);
  localparam logic [9:0]  PADDLE_MAX = 10'(H_ACTIVE - PADDLE_W);
  localparam logic [10:0] BALL_W11   = 11'(BALL_SIZE);
  localparam logic [9:0]  BALL_W10   = 10'(BALL_SIZE);
  localparam logic [10:0] PAD_W11    = 11'(PADDLE_W);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(MISS_FRAMES - 1);

  state_t          state_r, stateNext_s;
  logic [9:0]      ballX_r, ballXNext_s, xPos_s;
  logic [8:0]      ballY_r, ballYNext_s, yPos_s;
  logic            dirX_r, dirXNext_s, xDir_s;
  logic            dirY_r, dirYNext_s, yDir_s, yHitHigh_s;
  logic [7:0]      hitCount_r, hitNext_s;
  logic [3:0]      missCount_r, missNext_s;
  logic [TW-1:0]   missTimer_r, timerNext_s;
  logic [9:0]      paddle_r, paddleClamped_s;
  logic            serveLatch_r;
  logic            drawBall_r, drawPaddle_r;
  logic            tick_s, paddleHit_s, drawBallNext_s, drawPaddleNext_s;

  assign tick_s          = (counter_y == 9'(V_ACTIVE)) && (counter_x == 10'd0);
  assign paddleClamped_s = (paddle_x > PADDLE_MAX) ? PADDLE_MAX : paddle_x;
  assign paddleHit_s     = (({1'b0, ballX_r} + BALL_W11) > {1'b0, paddle_r}) &&
                           ({1'b0, ballX_r} < ({1'b0, paddle_r} + PAD_W11));

  axis_bounce #(.W(10), .STEP(STEP)) xAxis (
    .pos(ballX_r), .dir(dirX_r), .lowLimit(10'd0),
    .highLimit(10'(H_ACTIVE - BALL_SIZE)),
    .nextPos(xPos_s), .nextDir(xDir_s), .hitHigh()
  );

  // The Y high limit is the paddle line; hit vs. miss is decided here.
  axis_bounce #(.W(9), .STEP(STEP)) yAxis (
    .pos(ballY_r), .dir(dirY_r), .lowLimit(9'd0),
    .highLimit(9'(PADDLE_Y - BALL_SIZE)),
    .nextPos(yPos_s), .nextDir(yDir_s), .hitHigh(yHitHigh_s)
  );

  // Next-state and next-position logic, applied only on the frame tick.
  always_comb begin
    stateNext_s = state_r;
    ballXNext_s = ballX_r;
    ballYNext_s = ballY_r;
    dirXNext_s  = dirX_r;
    dirYNext_s  = dirY_r;
    hitNext_s   = hitCount_r;
    missNext_s  = missCount_r;
    timerNext_s = missTimer_r;
    case (state_r)
      ST_SERVE: begin
        if (serveLatch_r) begin
          stateNext_s = ST_PLAY;
          dirXNext_s  = 1'b1;
          dirYNext_s  = 1'b0;
        end else begin
          stateNext_s = ST_SERVE;
        end
      end
      ST_PLAY: begin
        if (yHitHigh_s && !paddleHit_s) begin
          stateNext_s = ST_MISS;
          missNext_s  = (missCount_r == 4'hF) ? missCount_r : missCount_r + 4'd1;
          timerNext_s = TIMER_LOAD;
        end else begin
          ballXNext_s = xPos_s;
          dirXNext_s  = xDir_s;
          ballYNext_s = yPos_s;
          dirYNext_s  = yDir_s;
          if (yHitHigh_s) begin
            hitNext_s = hitCount_r + 8'd1;
          end else begin
            hitNext_s = hitCount_r;
          end
        end
      end
      ST_MISS: begin
        if (missTimer_r == {TW{1'b0}}) begin
          stateNext_s = ST_SERVE;
          ballXNext_s = CENTRE_X;
          ballYNext_s = CENTRE_Y;
          dirXNext_s  = 1'b1;
          dirYNext_s  = 1'b0;
        end else begin
          timerNext_s = missTimer_r - TW'(1);
        end
      end
      default: begin
        stateNext_s = ST_SERVE;
        ballXNext_s = CENTRE_X;
        ballYNext_s = CENTRE_Y;
        dirXNext_s  = 1'b1;
        dirYNext_s  = 1'b0;
      end
    endcase
  end

  // Game state register; everything moves only on the frame tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_SERVE;
      ballX_r     <= CENTRE_X;
      ballY_r     <= CENTRE_Y;
      dirX_r      <= 1'b1;
      dirY_r      <= 1'b0;
      hitCount_r  <= 8'd0;
      missCount_r <= 4'd0;
      missTimer_r <= {TW{1'b0}};
      paddle_r    <= 10'd0;
    end else if (tick_s) begin
      state_r     <= stateNext_s;
      ballX_r     <= ballXNext_s;
      ballY_r     <= ballYNext_s;
      dirX_r      <= dirXNext_s;
      dirY_r      <= dirYNext_s;
      hitCount_r  <= hitNext_s;
      missCount_r <= missNext_s;
      missTimer_r <= timerNext_s;
      paddle_r    <= paddleClamped_s;
    end
  end

  // Serve request latch: armed only while waiting to serve, consumed by the tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      serveLatch_r <= 1'b0;
    end else if (tick_s) begin
      serveLatch_r <= 1'b0;
    end else if (serve && (state_r == ST_SERVE)) begin
      serveLatch_r <= 1'b1;
    end
  end

  assign drawBallNext_s = in_display_area &&
                          ({1'b0, counter_x} >= {1'b0, ballX_r}) &&
                          ({1'b0, counter_x} < ({1'b0, ballX_r} + BALL_W11)) &&
                          ({1'b0, counter_y} >= {1'b0, ballY_r}) &&
                          ({1'b0, counter_y} < ({1'b0, ballY_r} + BALL_W10));
  assign drawPaddleNext_s = in_display_area &&
                            (counter_x >= paddle_r) &&
                            ({1'b0, counter_x} < ({1'b0, paddle_r} + PAD_W11)) &&
                            (counter_y >= 9'(PADDLE_Y));

  // Draw flags registered every pixel to line up with the registered colour.
  always_ff @(posedge clk) begin
    if (reset) begin
      drawBall_r   <= 1'b0;
      drawPaddle_r <= 1'b0;
    end else begin
      drawBall_r   <= drawBallNext_s;
      drawPaddle_r <= drawPaddleNext_s;
    end
  end

  assign ball_x      = ballX_r;
  assign ball_y      = ballY_r;
  assign state       = state_r;
  assign hit_count   = hitCount_r;
  assign miss_count  = missCount_r;
  assign draw_ball   = drawBall_r;
  assign draw_paddle = drawPaddle_r;

endmodule

// File: tb/tb_ball_controller.sv
// Scoreboard bench for ball_controller: the bench plays sync generator,
// issuing single-cycle frame ticks, and checks against hand-derived trajectories.
module tb_ball_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] counter_x;
  logic [8:0] counter_y;
  logic       in_display_area;
  logic [9:0] paddle_x;
  logic       serve;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic       draw_ball;
  logic       draw_paddle;
  logic [1:0] state;
  logic [7:0] hit_count;
  logic [3:0] miss_count;

  ball_controller dut (
    .clk(clk), .reset(reset), .counter_x(counter_x), .counter_y(counter_y),
    .in_display_area(in_display_area), .paddle_x(paddle_x), .serve(serve),
    .ball_x(ball_x), .ball_y(ball_y), .draw_ball(draw_ball),
    .draw_paddle(draw_paddle), .state(state), .hit_count(hit_count),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          stamp;
    bit          isDraw;
    logic [32:0] expV;
    string       name;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  logic [32:0] act;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          k = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every expectation stamped for this cycle is popped and compared.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].stamp <= cyc) begin
      e = q.pop_front();
      vectors++;
      if (e.isDraw) act = {31'd0, draw_ball, draw_paddle};
      else          act = {state, ball_x, ball_y, hit_count, miss_count};
      if (e.stamp != cyc || act !== e.expV) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h (cycle %0d, due %0d)",
                 e.name, act, e.expV, cyc, e.stamp);
      end
    end
  end

  task automatic pushState(input string name, input int s, input int x,
                           input int y, input int h, input int m);
    exp_t t;
    t.stamp = cyc + 1; t.isDraw = 1'b0; t.name = name;
    t.expV = {2'(s), 10'(x), 9'(y), 8'(h), 4'(m)};
    q.push_back(t);
  endtask

  task automatic pushDraw(input string name, input int b, input int p);
    exp_t t;
    t.stamp = cyc + 1; t.isDraw = 1'b1; t.name = name;
    t.expV = {31'd0, 1'(b), 1'(p)};
    q.push_back(t);
  endtask

  task automatic drive(input int cx, input int cy, input int disp,
                       input int srv, input int rst);
    counter_x = 10'(cx); counter_y = 9'(cy);
    in_display_area = 1'(disp); serve = 1'(srv); reset = 1'(rst);
    @(posedge clk); #1;
  endtask

  task automatic tick();
    drive(0, 480, 0, 0, 0);
    drive(700, 500, 0, 0, 0);
    k++;
  endtask

  task automatic tickChk(input string name, input int s, input int x,
                         input int y, input int h, input int m);
    pushState(name, s, x, y, h, m);
    tick();
  endtask

  task automatic checkAt(input string name, input int target, input int s,
                         input int x, input int y, input int h, input int m);
    while (k < target - 1) tick();
    tickChk(name, s, x, y, h, m);
  endtask

  initial begin
    paddle_x = 10'd0;
    drive(700, 500, 0, 0, 1);
    pushState("reset_state", 0, 312, 232, 0, 0);
    pushDraw("reset_draw", 0, 0);
    drive(700, 500, 0, 0, 1);

    // Three partial frames around the centred ball, serve held low.
    for (int f = 0; f < 3; f++) begin
      for (int y = 230; y < 250; y++) begin
        for (int x = 308; x < 332; x++) begin
          int disp;
          disp = (f == 2 && y == 240) ? 0 : 1;
          pushDraw("draw_centre", (disp == 1 && x >= 312 && x <= 327 &&
                                   y >= 232 && y <= 247) ? 1 : 0, 0);
          drive(x, y, disp, 0, 0);
        end
      end
      tickChk("serve_hold", 0, 312, 232, 0, 0);
    end

    // Serve pulse mid-frame, then play through wall, ceiling and paddle bounces.
    paddle_x = 10'd220;
    drive(100, 100, 1, 1, 0);
    drive(700, 500, 0, 0, 0);
    tickChk("serve_tick", 1, 312, 232, 0, 0);
    k = 0;
    tickChk("play_k1", 1, 314, 230, 0, 0);
    checkAt("top_reach", 116, 1, 544, 0, 0, 0);
    checkAt("top_bounce", 117, 1, 546, 0, 0, 0);
    checkAt("right_reach", 156, 1, 624, 78, 0, 0);
    checkAt("right_bounce", 157, 1, 624, 80, 0, 0);
    checkAt("right_leave", 158, 1, 622, 82, 0, 0);
    checkAt("paddle_near", 341, 1, 256, 448, 0, 0);
    checkAt("paddle_hit", 342, 1, 254, 448, 1, 0);
    checkAt("paddle_leave", 343, 1, 252, 446, 1, 0);
    paddle_x = 10'd0;
    checkAt("left_reach", 469, 1, 0, 194, 1, 0);
    checkAt("left_bounce", 470, 1, 0, 192, 1, 0);
    checkAt("left_leave", 471, 1, 2, 190, 1, 0);
    checkAt("top2_reach", 566, 1, 192, 0, 1, 0);
    checkAt("top2_bounce", 567, 1, 194, 0, 1, 0);
    checkAt("right2_reach", 782, 1, 624, 430, 1, 0);
    checkAt("paddle2_near", 791, 1, 608, 448, 1, 0);
    checkAt("miss", 792, 2, 608, 448, 1, 1);
    checkAt("miss_hold", 851, 2, 608, 448, 1, 1);
    drive(100, 100, 1, 1, 0);
    checkAt("miss_to_serve", 852, 0, 312, 232, 1, 1);
    tickChk("serve_ignored_in_miss", 0, 312, 232, 1, 1);

    // Paddle clamp: request beyond the right edge.
    paddle_x = 10'd700;
    tick();
    for (int r = 0; r < 4; r++) begin
      int y;
      y = (r == 3) ? 479 : 462 + r;
      for (int c = 0; c < 7; c++) begin
        int x;
        x = (c < 4) ? 574 + c : 632 + 3 * (c - 4) + ((c == 6) ? 1 : 0);
        pushDraw("draw_paddle", 0, (y >= 464 && x >= 576 && x <= 639) ? 1 : 0);
        drive(x, y, 1, 0, 0);
      end
    end
    pushDraw("draw_paddle_blank", 0, 0);
    drive(600, 470, 0, 0, 0);

    // Repeated misses: the counter must saturate at 15.
    paddle_x = 10'd0;
    for (int n = 2; n <= 17; n++) begin
      drive(100, 100, 1, 1, 0);
      tick();
      k = 0;
      checkAt("miss_repeat", 342, 2, 256, 448, 1, (n > 15) ? 15 : n);
      for (int i = 0; i < 59; i++) tick();
      tickChk("miss_recover", 0, 312, 232, 1, (n > 15) ? 15 : n);
    end

    // Reset in mid-line during PLAY.
    drive(100, 100, 1, 1, 0);
    tick();
    tickChk("play_again", 1, 314, 230, 1, 15);
    tick();
    pushDraw("draw_before_reset", 1, 0);
    drive(320, 230, 1, 0, 0);
    pushState("midplay_reset", 0, 312, 232, 0, 0);
    pushDraw("midplay_reset_draw", 0, 0);
    drive(320, 230, 1, 0, 1);
    drive(700, 500, 0, 0, 0);
    drive(700, 500, 0, 0, 0);

    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
